// File: rtl/trace_drain_if.sv
// Output beat stream of the trace drain.
// The DUT drives through master; the sink uses slave.
interface trace_drain_if #(
  parameter int WORD_WIDTH = 32
) ();
  logic [WORD_WIDTH-1:0] word_o;
  logic                  word_valid_o;
  logic                  word_ready_i;
  logic                  word_last_o;

  modport master (
    output word_o,
    output word_valid_o,
    output word_last_o,
    input  word_ready_i
  );

  modport slave (
    input  word_o,
    input  word_valid_o,
    input  word_last_o,
    output word_ready_i
  );
endinterface

// File: rtl/trace_drain.sv
// Buffers packed trace records in a FIFO and streams them out
// as WORD_WIDTH beats, LSW first, until lock is seen and drained.
module trace_drain #(
  parameter int TRACE_WIDTH = 96,
  parameter int WORD_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TRACE_WIDTH-1:0] trace_data_i,
  input  logic                   trace_ready_i,
  input  logic                   trace_capture_enable_i,
  input  logic                   lock_i,
  trace_drain_if.master          word,
  output logic                   overflow_o,
  output logic [15:0]            dropped_count_o,
  output logic [31:0]            records_sent_o,
  output logic                   drained_o
);
  localparam int BEATS = TRACE_WIDTH / WORD_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic          ONE_BEAT  = (BEATS == 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state;
  logic [TRACE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]            wptr;
  logic [AW:0]            rptr;
  logic [TRACE_WIDTH-1:0] shreg;
  logic [TRACE_WIDTH-1:0] shifted;
  logic [TRACE_WIDTH-1:0] head;
  logic [BW-1:0]          beat;
  logic                   lock_q;
  logic                   empty;
  logic                   full;
  logic                   push_req;
  logic                   push;
  logic                   drop;
  logic                   pop;
  logic                   accept;
  logic                   last_acc;

  assign empty    = wptr == rptr;
  assign full     = (wptr[AW] != rptr[AW]) &&
                    (wptr[AW-1:0] == rptr[AW-1:0]);
  assign accept   = (state == SEND) && word.word_valid_o &&
                    word.word_ready_i;
  assign last_acc = accept && (beat == LAST_BEAT);
  assign pop      = !empty && ((state == IDLE) || last_acc);
  assign push_req = trace_ready_i && trace_capture_enable_i &&
                    (state != DONE);
  // A full FIFO still takes the record if the head leaves this cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;
  assign shifted  = shreg >> WORD_WIDTH;
  assign head     = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= trace_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      wptr              <= '0;
      rptr              <= '0;
      shreg             <= '0;
      beat              <= '0;
      lock_q            <= 1'b0;
      word.word_o       <= '0;
      word.word_valid_o <= 1'b0;
      word.word_last_o  <= 1'b0;
      overflow_o        <= 1'b0;
      dropped_count_o   <= '0;
      records_sent_o    <= '0;
      drained_o         <= 1'b0;
    end else begin
      lock_q <= lock_q | lock_i;
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      if (drop) begin
        overflow_o <= 1'b1;
        if (dropped_count_o != 16'hFFFF)
          dropped_count_o <= dropped_count_o + 16'd1;
      end
      unique case (state)
        IDLE: begin
          // A record landing this cycle must be sent before DONE.
          if (empty && lock_q && !push) begin
            state     <= DONE;
            drained_o <= 1'b1;
          end
        end
        SEND: begin
          if (accept && !last_acc) begin
            beat             <= beat + BEAT_ONE;
            shreg            <= shifted;
            word.word_o      <= shifted[WORD_WIDTH-1:0];
            word.word_last_o <= (beat + BEAT_ONE) == LAST_BEAT;
          end else if (last_acc) begin
            records_sent_o    <= records_sent_o + 32'd1;
            word.word_o       <= '0;
            word.word_valid_o <= 1'b0;
            word.word_last_o  <= 1'b0;
            if (lock_q && !push) begin
              state     <= DONE;
              drained_o <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
      if (pop) begin
        state             <= SEND;
        shreg             <= head;
        beat              <= '0;
        word.word_o       <= head[WORD_WIDTH-1:0];
        word.word_valid_o <= 1'b1;
        word.word_last_o  <= ONE_BEAT;
        drained_o         <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_trace_drain.sv
// Bench for trace_drain: vector table, scoreboard of expected
// beats, and hand sequences for backpressure, overflow, lock, reset.
module tb_trace_drain;
  localparam int TW = 96;
  localparam int WW = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [TW-1:0] trace_data_i;
  logic          trace_ready_i;
  logic          trace_capture_enable_i;
  logic          lock_i;
  logic          overflow_o;
  logic [15:0]   dropped_count_o;
  logic [31:0]   records_sent_o;
  logic          drained_o;

  always #5 clk = ~clk;

  trace_drain_if #(.WORD_WIDTH(WW)) wif ();

  trace_drain #(
    .TRACE_WIDTH(TW),
    .WORD_WIDTH(WW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .trace_data_i(trace_data_i),
    .trace_ready_i(trace_ready_i),
    .trace_capture_enable_i(trace_capture_enable_i),
    .lock_i(lock_i),
    .word(wif),
    .overflow_o(overflow_o),
    .dropped_count_o(dropped_count_o),
    .records_sent_o(records_sent_o),
    .drained_o(drained_o)
  );

  typedef struct {
    logic [31:0] w;
    logic        last;
  } beat_t;

  typedef struct {
    logic [TW-1:0] data;
    logic          en;
    logic          queued;
  } vec_t;

  int    total = 0;
  int    bad = 0;
  int    exp_sent = 0;
  beat_t sbq[$];
  vec_t  vt[8];

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic queue_rec(input logic [TW-1:0] d);
    for (int b = 0; b < 3; b++) begin
      beat_t e;
      e.w = d[32*b +: 32];
      e.last = (b == 2);
      sbq.push_back(e);
    end
    exp_sent++;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sbq.size() != 0 || wif.word_valid_o) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL drain_timeout: got %0d beats left want 0",
               sbq.size());
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, wif.word_valid_o, 0);
    chk({tag, "_last"}, wif.word_last_o, 0);
    chk({tag, "_word"}, wif.word_o, 0);
    chk({tag, "_ovf"}, overflow_o, 0);
    chk({tag, "_drop"}, dropped_count_o, 0);
    chk({tag, "_sent"}, records_sent_o, 0);
    chk({tag, "_drained"}, drained_o, 0);
  endtask

  logic        hold = 1'b0;
  logic [31:0] hold_w;
  logic        hold_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", wif.word_valid_o, 1);
        chk("hold_word", wif.word_o, hold_w);
        chk("hold_last", wif.word_last_o, hold_l);
      end
      if (wif.word_valid_o && wif.word_ready_i) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %0h want no beat", wif.word_o);
        end else begin
          beat_t e;
          e = sbq.pop_front();
          chk("beat_word", wif.word_o, e.w);
          chk("beat_last", wif.word_last_o, e.last);
        end
      end
      hold = wif.word_valid_o && !wif.word_ready_i;
      hold_w = wif.word_o;
      hold_l = wif.word_last_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] d;
    vt[0] = '{96'h0000000c_0000000b_0000000a, 1'b1, 1'b1};
    vt[1] = '{96'h11111113_11111112_11111111, 1'b0, 1'b0};
    vt[2] = '{96'hdeadbeef_cafef00d_12345678, 1'b1, 1'b1};
    vt[3] = '{96'hffffffff_00000000_ffffffff, 1'b1, 1'b1};
    vt[4] = '{96'h22222223_22222222_22222221, 1'b0, 1'b0};
    vt[5] = '{96'h80000000_00000001_7fffffff, 1'b1, 1'b1};
    vt[6] = '{96'h0000_0000_0000_0000_0000_0000, 1'b1, 1'b1};
    vt[7] = '{96'ha5a5a5a5_5a5a5a5a_a5a5a5a5, 1'b1, 1'b1};

    trace_data_i = '0;
    trace_ready_i = 1'b0;
    trace_capture_enable_i = 1'b0;
    lock_i = 1'b0;
    wif.word_ready_i = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // single record, latency and beat order
    wif.word_ready_i = 1'b1;
    d = {32'd3, 32'd2, 32'd1};
    trace_data_i = d;
    trace_ready_i = 1'b1;
    trace_capture_enable_i = 1'b1;
    queue_rec(d);
    tick();
    trace_ready_i = 1'b0;
    chk("lat_t1_valid", wif.word_valid_o, 0);
    tick();
    chk("lat_t2_valid", wif.word_valid_o, 1);
    chk("lat_t2_word", wif.word_o, 1);
    chk("lat_t2_last", wif.word_last_o, 0);
    tick();
    chk("lat_t3_word", wif.word_o, 2);
    chk("lat_t3_last", wif.word_last_o, 0);
    tick();
    chk("lat_t4_word", wif.word_o, 3);
    chk("lat_t4_last", wif.word_last_o, 1);
    tick();
    chk("lat_t5_valid", wif.word_valid_o, 0);
    chk("lat_sent", records_sent_o, exp_sent);

    // table of strobes under random backpressure
    for (int i = 0; i < 8; i++) begin
      trace_data_i = vt[i].data;
      trace_ready_i = 1'b1;
      trace_capture_enable_i = vt[i].en;
      if (vt[i].queued) queue_rec(vt[i].data);
      wif.word_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    trace_ready_i = 1'b0;
    trace_capture_enable_i = 1'b1;
    wif.word_ready_i = 1'b1;
    wait_drain(200);
    chk("tbl_ovf", overflow_o, 0);
    chk("tbl_drop", dropped_count_o, 0);
    chk("tbl_sent", records_sent_o, exp_sent);

    // long stall on beat 1
    d = 96'hcccc0003_bbbb0002_aaaa0001;
    trace_data_i = d;
    trace_ready_i = 1'b1;
    queue_rec(d);
    tick();
    trace_ready_i = 1'b0;
    tick();
    tick();
    wif.word_ready_i = 1'b0;
    repeat (10) tick();
    chk("stall_valid", wif.word_valid_o, 1);
    chk("stall_word", wif.word_o, 32'hbbbb0002);
    wif.word_ready_i = 1'b1;
    wait_drain(50);
    chk("stall_sent", records_sent_o, exp_sent);

    // ten strobes into a stalled sink
    wif.word_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      d = {32'h300 + 32'(k), 32'h200 + 32'(k), 32'h100 + 32'(k)};
      trace_data_i = d;
      trace_ready_i = 1'b1;
      if (k < 9) queue_rec(d);
      tick();
    end
    trace_ready_i = 1'b0;
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_drop", dropped_count_o, 1);
    wif.word_ready_i = 1'b1;
    wait_drain(300);
    chk("ovf_sent", records_sent_o, exp_sent);

    // lock with three queued records
    wif.word_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = {32'h5000 + 32'(k), 32'h4000 + 32'(k), 32'h3000 + 32'(k)};
      trace_data_i = d;
      trace_ready_i = 1'b1;
      queue_rec(d);
      tick();
    end
    trace_ready_i = 1'b0;
    lock_i = 1'b1;
    tick();
    lock_i = 1'b0;
    wif.word_ready_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("b2b_valid", wif.word_valid_o, 1);
      tick();
    end
    chk("done_drained", drained_o, 1);
    chk("done_valid", wif.word_valid_o, 0);
    chk("done_sent", records_sent_o, exp_sent);
    for (int k = 0; k < 3; k++) begin
      trace_data_i = {3{32'h77}};
      trace_ready_i = 1'b1;
      tick();
    end
    trace_ready_i = 1'b0;
    tick();
    tick();
    chk("done_hold_drained", drained_o, 1);
    chk("done_hold_valid", wif.word_valid_o, 0);
    chk("done_hold_drop", dropped_count_o, 1);
    chk("done_hold_sent", records_sent_o, exp_sent);

    // reset mid-record
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_sent = 0;
    sbq.delete();
    tick();
    chk("rst2_sent", records_sent_o, 0);
    chk("rst2_drained", drained_o, 0);
    wif.word_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = {32'h9000 + 32'(k), 32'h8000 + 32'(k), 32'h7000 + 32'(k)};
      trace_data_i = d;
      trace_ready_i = 1'b1;
      queue_rec(d);
      tick();
    end
    trace_ready_i = 1'b0;
    wif.word_ready_i = 1'b1;
    tick();
    wif.word_ready_i = 1'b0;
    chk("mid_word", wif.word_o, 32'h8000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    sbq.delete();
    exp_sent = 0;
    tick();
    tick();
    rst_n = 1'b1;
    wif.word_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_valid", wif.word_valid_o, 0);
    end
    chk("post_rst_sent", records_sent_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trace_drain.md
TRACE_DRAIN -- requirements
Module: trace_drain

Interface
REQ-001 SHALL have parameter TRACE_WIDTH, default 96, meaning packed trace record width in bits.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, meaning output beat width; TRACE_WIDTH SHALL be an integer multiple of it, giving BEATS = TRACE_WIDTH/WORD_WIDTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning record FIFO depth (power of two, at least 2).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 trace_data_i  input  TRACE_WIDTH  packed trace record from the trace unit.
REQ-007 trace_ready_i  input  1  one-cycle strobe qualifying trace_data_i.
REQ-008 trace_capture_enable_i  input  1  strobes SHALL be ignored while low.
REQ-009 lock_i  input  1  trace unit has locked; no further records expected.
REQ-010 word_o  output  WORD_WIDTH  current output beat.
REQ-011 word_valid_o  output  1  word_o valid.
REQ-012 word_ready_i  input  1  downstream accepts beat when high with word_valid_o.
REQ-013 word_last_o  output  1  high on the final beat of a record.
REQ-014 overflow_o  output  1  sticky: at least one record dropped.
REQ-015 dropped_count_o  output  16  records dropped, saturating at 16'hFFFF.
REQ-016 records_sent_o  output  32  records fully transmitted, wrapping modulo 2^32.
REQ-017 drained_o  output  1  lock seen and every accepted record transmitted.

Function
REQ-018 Push: trace_ready_i && trace_capture_enable_i in cycle t SHALL write trace_data_i into the FIFO at the end of cycle t.
REQ-019 Push while FIFO full SHALL be accepted only if a pop occurs in the same cycle; otherwise the record SHALL be dropped, overflow_o set and dropped_count_o incremented (saturating).
REQ-020 FSM states SHALL be IDLE, SEND, DONE.
REQ-021 IDLE: FIFO non-empty -> pop head into a TRACE_WIDTH shift register, beat index = 0, go to SEND; FIFO empty and lock latched -> DONE; otherwise stay IDLE.
REQ-022 SEND: word_valid_o = 1; word_o = bits [WORD_WIDTH*(beat+1)-1 : WORD_WIDTH*beat] of the shift register (least significant word first); word_last_o = (beat == BEATS-1).
REQ-023 In SEND, word_o, word_valid_o and word_last_o SHALL hold stable until word_ready_i is sampled high.
REQ-024 On an accepted beat that is not last, beat SHALL increment by 1.
REQ-025 On an accepted last beat: records_sent_o increments; then FIFO non-empty -> pop next record, beat = 0, stay SEND (back-to-back, no idle cycle); else lock latched -> DONE; else -> IDLE.
REQ-026 Latency: a record pushed in cycle t with the FIFO empty and FSM in IDLE SHALL present its first beat (word_valid_o high) in cycle t+2.
REQ-027 lock_i SHALL be latched into a sticky lock flag on the first rising edge it is sampled high.
REQ-028 Pushes after lock is latched SHALL still be accepted while trace_capture_enable_i is high; records in the FIFO SHALL always be transmitted before DONE.
REQ-029 DONE: drained_o = 1, word_valid_o = 0, all further strobes ignored and not counted as drops, until reset.
REQ-030 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap; full and empty SHALL be distinguished by the pointer MSB.
REQ-031 A record delivered at the moment word_ready_i is held low indefinitely SHALL NOT be lost; backpressure only fills the FIFO, and drops follow REQ-019.

Reset
REQ-032 rst_n low SHALL immediately force FSM IDLE, FIFO empty, beat 0, lock flag 0, word_valid_o 0, word_last_o 0, word_o 0, overflow_o 0, dropped_count_o 0, records_sent_o 0, drained_o 0.
REQ-033 Reset asserted mid-record SHALL discard the partial record and all FIFO contents; no beat SHALL be emitted in the first cycle after release.

Verification
REQ-034 Single record 0x3_2_1 (words 0x00000001, 0x00000002, 0x00000003) at t, word_ready_i=1 -> beats 1,2,3 in t+2..t+4, word_last_o only at t+4, records_sent_o=1.
REQ-035 word_ready_i=0 for 10 cycles during beat 1 -> word_o holds 0x00000002 stable, then resumes; no beat duplicated or skipped.
REQ-036 Ten strobes in consecutive cycles with word_ready_i=0, FIFO_DEPTH=8 -> 8 records stored (or 9 if a pop overlaps), overflow_o=1, dropped_count_o = 10 - stored; all stored records later sent in order.
REQ-037 Three records queued then lock_i pulsed for one cycle -> all 3 sent back-to-back (9 beats, no gaps), then drained_o=1 and later strobes ignored.
REQ-038 Strobes with trace_capture_enable_i=0 -> nothing queued, overflow_o stays 0.
REQ-039 rst_n asserted during beat 1 of a record with 2 more queued -> outputs zero at once; after release word_valid_o stays 0 and records_sent_o=0.
